// File: rtl/afu_cmd_credit_arbiter.sv
// afu_cmd_credit_arbiter: credit-gated N-channel command arbiter; define AFU_CMD_ARB_STATS_EN to add grant/stall counters
module afu_cmd_credit_arbiter #(
  parameter int NUM_CHANNELS  = 5,
  parameter int CMD_WIDTH     = 64,
  parameter int CREDITS_READ  = 32,
  parameter int CREDITS_WRITE = 32,
  parameter int ROUND_ROBIN   = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [NUM_CHANNELS-1:0]                req_valid,
  input  logic [NUM_CHANNELS-1:0]                req_is_write,
  input  logic [NUM_CHANNELS*CMD_WIDTH-1:0]      req_cmd,
  output logic [NUM_CHANNELS-1:0]                grant,
  output logic                                   out_valid,
  output logic                                   out_is_write,
  output logic [CMD_WIDTH-1:0]                   out_cmd,
  output logic [$clog2(NUM_CHANNELS)-1:0]        out_channel,
  input  logic                                   rsp_read_done,
  input  logic                                   rsp_write_done,
  output logic [$clog2(CREDITS_READ+1)-1:0]      read_credits,
  output logic [$clog2(CREDITS_WRITE+1)-1:0]     write_credits,
  output logic                                   credit_error
`ifdef AFU_CMD_ARB_STATS_EN
  ,
  output logic [31:0]                            read_grant_count,
  output logic [31:0]                            write_grant_count,
  output logic [31:0]                            credit_stall_count
`endif
);
  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int RW = $clog2(CREDITS_READ+1);
  localparam int WW = $clog2(CREDITS_WRITE+1);
  if (CREDITS_READ + CREDITS_WRITE > 64) begin : g_pool_check
    $error("CREDITS_READ + CREDITS_WRITE must not exceed 64");
  end
  logic [NUM_CHANNELS-1:0] eligible;
  logic [CW-1:0] rr_ptr, sel;
  logic [CW:0] cand;
  logic hit, rd_take, wr_take, rd_ovf, wr_ovf;
  assign eligible = {NUM_CHANNELS{enable & ~reset}} & req_valid &
                    ((req_is_write & {NUM_CHANNELS{write_credits != '0}}) |
                     (~req_is_write & {NUM_CHANNELS{read_credits != '0}}));
  // Scan from the farthest offset down so the nearest eligible channel to rr_ptr wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    cand = '0;
    for (int j = NUM_CHANNELS-1; j >= 0; j--) begin
      cand = {1'b0, rr_ptr} + (CW+1)'(j);
      cand = cand >= (CW+1)'(NUM_CHANNELS) ? cand - (CW+1)'(NUM_CHANNELS) : cand;
      if (eligible[cand[CW-1:0]]) begin
        sel = cand[CW-1:0];
        hit = 1'b1;
      end
    end
  end
  assign grant   = hit ? NUM_CHANNELS'(1) << sel : '0;
  assign rd_take = |(grant & ~req_is_write);
  assign wr_take = |(grant & req_is_write);
  assign rd_ovf  = rsp_read_done & ~rd_take & (read_credits == RW'(CREDITS_READ));
  assign wr_ovf  = rsp_write_done & ~wr_take & (write_credits == WW'(CREDITS_WRITE));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_valid     <= 1'b0;
      out_is_write  <= 1'b0;
      out_cmd       <= '0;
      out_channel   <= '0;
      rr_ptr        <= '0;
      read_credits  <= RW'(CREDITS_READ);
      write_credits <= WW'(CREDITS_WRITE);
      credit_error  <= 1'b0;
    end else begin
      out_valid <= hit;
      if (hit) begin
        out_is_write <= req_is_write[sel];
        out_cmd      <= req_cmd[sel*CMD_WIDTH +: CMD_WIDTH];
        out_channel  <= sel;
      end
      if (hit && ROUND_ROBIN != 0) rr_ptr <= sel == CW'(NUM_CHANNELS-1) ? '0 : sel + CW'(1);
      read_credits  <= read_credits + RW'(rsp_read_done & ~rd_ovf) - RW'(rd_take);
      write_credits <= write_credits + WW'(rsp_write_done & ~wr_ovf) - WW'(wr_take);
      credit_error  <= credit_error | rd_ovf | wr_ovf;
    end
`ifdef AFU_CMD_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      read_grant_count   <= '0;
      write_grant_count  <= '0;
      credit_stall_count <= '0;
    end else begin
      read_grant_count   <= read_grant_count + 32'(rd_take);
      write_grant_count  <= write_grant_count + 32'(wr_take);
      credit_stall_count <= credit_stall_count + 32'(enable & |req_valid & ~hit);
    end
`endif
endmodule

// File: tb/tb_afu_cmd_credit_arbiter.sv
// tb_afu_cmd_credit_arbiter: fixed-priority and round-robin instances against a behavioural model
module tb_afu_cmd_credit_arbiter;
  localparam int N = 5, CR = 32, CWR = 32;
  logic clock = 0, reset = 0, enable = 0, rsp_read_done = 0, rsp_write_done = 0;
  logic [N-1:0] req_valid = '0, req_is_write = '0;
  logic [N*64-1:0] req_cmd = '0;
  logic [N-1:0] grant [2];
  logic out_valid [2], out_is_write [2], credit_error [2];
  logic [63:0] out_cmd [2];
  logic [2:0] out_channel [2];
  logic [5:0] read_credits [2], write_credits [2];
`ifdef AFU_CMD_ARB_STATS_EN
  logic [31:0] rg_cnt [2], wg_cnt [2], st_cnt [2];
`endif
  int vectors = 0, miscompares = 0;
  int m_rc [2], m_wc [2], m_rr [2], m_ch [2], lg [2];
  bit m_ov [2], m_ow [2], m_err [2];
  logic [63:0] m_cmd [2];
  int unsigned m_rg [2], m_wg [2], m_st [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    afu_cmd_credit_arbiter #(.NUM_CHANNELS(N), .CMD_WIDTH(64), .CREDITS_READ(CR),
                             .CREDITS_WRITE(CWR), .ROUND_ROBIN(g)) u_dut (
      .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid),
      .req_is_write(req_is_write), .req_cmd(req_cmd), .grant(grant[g]),
      .out_valid(out_valid[g]), .out_is_write(out_is_write[g]), .out_cmd(out_cmd[g]),
      .out_channel(out_channel[g]), .rsp_read_done(rsp_read_done),
      .rsp_write_done(rsp_write_done), .read_credits(read_credits[g]),
      .write_credits(write_credits[g]), .credit_error(credit_error[g])
`ifdef AFU_CMD_ARB_STATS_EN
      , .read_grant_count(rg_cnt[g]), .write_grant_count(wg_cnt[g]),
      .credit_stall_count(st_cnt[g])
`endif
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int m);
    m_rc[m] = CR; m_wc[m] = CWR; m_rr[m] = 0; m_ch[m] = 0;
    m_ov[m] = 0; m_ow[m] = 0; m_err[m] = 0; m_cmd[m] = '0;
    m_rg[m] = 0; m_wg[m] = 0; m_st[m] = 0;
  endtask

  // Instance 0 always scans from channel 0; instance 1 scans from its rotating start.
  function automatic int pick(input int m);
    if (reset || !enable) return -1;
    for (int o = 0; o < N; o++) begin
      int k;
      k = (m_rr[m] + o) % N;
      if (req_valid[k] && (req_is_write[k] ? m_wc[m] > 0 : m_rc[m] > 0)) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input int m, input int g);
    bit rt, wt;
    if (reset) begin
      model_reset(m);
      return;
    end
    rt = 0; wt = 0;
    if (g >= 0) begin
      wt = req_is_write[g];
      rt = !wt;
      m_ow[m] = wt; m_ch[m] = g; m_cmd[m] = req_cmd[g*64 +: 64];
      if (m == 1) m_rr[m] = (g + 1) % N;
    end
    m_ov[m] = g >= 0;
    if (rsp_read_done && !rt && m_rc[m] == CR) m_err[m] = 1;
    else m_rc[m] = m_rc[m] + int'(rsp_read_done) - int'(rt);
    if (rsp_write_done && !wt && m_wc[m] == CWR) m_err[m] = 1;
    else m_wc[m] = m_wc[m] + int'(rsp_write_done) - int'(wt);
    m_rg[m] += rt; m_wg[m] += wt;
    if (g < 0 && enable && |req_valid) m_st[m]++;
  endtask

  task automatic check_regs(input int m);
    chk($sformatf("out_valid%0d", m), out_valid[m], m_ov[m]);
    chk($sformatf("out_is_write%0d", m), out_is_write[m], m_ow[m]);
    chk($sformatf("out_cmd%0d", m), out_cmd[m], m_cmd[m]);
    chk($sformatf("out_channel%0d", m), out_channel[m], m_ch[m]);
    chk($sformatf("read_credits%0d", m), read_credits[m], m_rc[m]);
    chk($sformatf("write_credits%0d", m), write_credits[m], m_wc[m]);
    chk($sformatf("credit_error%0d", m), credit_error[m], m_err[m]);
`ifdef AFU_CMD_ARB_STATS_EN
    chk($sformatf("read_grant_count%0d", m), rg_cnt[m], m_rg[m]);
    chk($sformatf("write_grant_count%0d", m), wg_cnt[m], m_wg[m]);
    chk($sformatf("credit_stall_count%0d", m), st_cnt[m], m_st[m]);
`endif
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    for (int m = 0; m < 2; m++) begin
      lg[m] = pick(m);
      chk($sformatf("grant%0d", m), grant[m], lg[m] < 0 ? 64'd0 : 64'd1 << lg[m]);
    end
    @(posedge clock);
    for (int m = 0; m < 2; m++) model_edge(m, lg[m]);
    @(negedge clock);
    for (int m = 0; m < 2; m++) check_regs(m);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_grant%0d", m), grant[m], 0);
      chk($sformatf("rst_out_valid%0d", m), out_valid[m], 0);
      chk($sformatf("rst_out_channel%0d", m), out_channel[m], 0);
      chk($sformatf("rst_read_credits%0d", m), read_credits[m], CR);
      chk($sformatf("rst_write_credits%0d", m), write_credits[m], CWR);
      chk($sformatf("rst_credit_error%0d", m), credit_error[m], 0);
    end
    @(negedge clock);
    reset = 0;
    for (int m = 0; m < 2; m++) model_reset(m);
  endtask

  task automatic drive(input bit en, input logic [N-1:0] v, input logic [N-1:0] w,
                       input bit rr, input bit rw);
    enable = en; req_valid = v; req_is_write = w;
    rsp_read_done = rr; rsp_write_done = rw;
    for (int c = 0; c < N; c++) req_cmd[c*64 +: 64] = {$urandom, $urandom};
  endtask

  typedef struct {
    bit en;
    logic [N-1:0] v, w;
    bit rr, rw;
    logic [N-1:0] g;
    int rc, wc;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 5'b11111, 5'b00000, 0, 0, 5'b00001, 31, 32};
    tbl[1] = '{1, 5'b11111, 5'b00000, 0, 0, 5'b00001, 30, 32};
    tbl[2] = '{0, 5'b11111, 5'b00000, 0, 0, 5'b00000, 30, 32};
    tbl[3] = '{1, 5'b00110, 5'b00100, 0, 0, 5'b00010, 29, 32};
    tbl[4] = '{1, 5'b00100, 5'b00100, 0, 0, 5'b00100, 29, 31};
    tbl[5] = '{1, 5'b00000, 5'b00000, 1, 0, 5'b00000, 30, 31};
    tbl[6] = '{1, 5'b11000, 5'b11000, 0, 1, 5'b01000, 30, 31};
    tbl[7] = '{1, 5'b00001, 5'b00000, 1, 0, 5'b00001, 30, 31};
    #2;
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].w, tbl[i].rr, tbl[i].rw);
      #1 chk($sformatf("tbl%0d_grant", i), grant[0], tbl[i].g);
      cycle();
      chk($sformatf("tbl%0d_read_credits", i), read_credits[0], tbl[i].rc);
      chk($sformatf("tbl%0d_write_credits", i), write_credits[0], tbl[i].wc);
    end
    // Exhaust read pool, then a write still gets through.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'b11111, 5'b00000, 0, 0);
      cycle();
    end
    chk("rd_empty_credits", read_credits[0], 0);
    drive(1, 5'b11111, 5'b00000, 0, 0);
    #1 chk("rd_empty_grant", grant[0], 0);
    cycle();
    drive(1, 5'b11111, 5'b00100, 0, 0);
    #1 chk("write_bypass_grant", grant[0], 5'b00100);
    cycle();
    chk("write_bypass_credits", write_credits[0], 31);
    // Round-robin rotation over channels 0, 2, 4.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      int exp_ch;
      exp_ch = (2 * i) % 6;
      drive(1, 5'b10101, 5'b00000, 0, 0);
      #1 chk($sformatf("rr_grant%0d", i), grant[1], 64'd1 << exp_ch);
      cycle();
      chk($sformatf("rr_out_channel%0d", i), out_channel[1], exp_ch);
    end
    // Simultaneous grant and return leaves the pool unchanged.
    do_reset();
    for (int i = 0; i < 27; i++) begin
      drive(1, 5'b11111, 5'b00000, 0, 0);
      cycle();
    end
    chk("rc_at_5", read_credits[0], 5);
    drive(1, 5'b11111, 5'b00000, 1, 0);
    cycle();
    chk("rc_grant_and_return", read_credits[0], 5);
    // Overflow on full write pool is sticky.
    do_reset();
    drive(1, 5'b00000, 5'b00000, 0, 1);
    cycle();
    chk("ovf_write_credits", write_credits[0], 32);
    chk("ovf_error", credit_error[0], 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'b00000, 5'b00000, 0, 0);
      cycle();
    end
    chk("ovf_error_sticky", credit_error[0], 1);
    // Mid-stream asynchronous reset.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(1, 5'b11111, 5'b00000, 0, 0);
      cycle();
    end
    chk("mid_rc_10", read_credits[0], 10);
    chk("mid_out_valid", out_valid[0], 1);
    #2;
    do_reset();
    drive(1, 5'b11111, 5'b00000, 0, 0);
    #1 chk("post_reset_grant_fixed", grant[0], 5'b00001);
    chk("post_reset_grant_rr", grant[1], 5'b00001);
    cycle();
    // Randomised traffic: scarce returns first, then plentiful ones.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, N'($urandom), N'($urandom),
            $urandom_range(0, 99) < (i < 200 ? 15 : 55),
            $urandom_range(0, 99) < (i < 200 ? 15 : 55));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
